// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, head-flit field layout and
// mesh-id helpers used by the PE network interfaces.
package noc_pkg;

   localparam int unsigned FLIT_TYPE_W = 2;

   typedef enum logic [FLIT_TYPE_W-1:0] {
      FLIT_BODY = 2'b00,
      FLIT_HEAD = 2'b01,
      FLIT_TAIL = 2'b10
   } flit_type_e;

   localparam int unsigned HDR_DEST_LSB = 28;
   localparam int unsigned HDR_DEST_W   = 4;
   localparam int unsigned HDR_SRC_LSB  = 24;
   localparam int unsigned HDR_SRC_W    = 4;
   localparam int unsigned HDR_LEN_LSB  = 16;
   localparam int unsigned HDR_LEN_W    = 8;
   localparam int unsigned HDR_SEQ_LSB  = 0;
   localparam int unsigned HDR_SEQ_W    = 16;

   function automatic logic [1:0] node_x(input logic [3:0] id);
      return id[1:0];
   endfunction

   function automatic logic [1:0] node_y(input logic [3:0] id);
      return id[3:2];
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push while full is dropped and a
// pop while empty is ignored.
module noc_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit separates the full and empty cases when the indices match.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/noc_pe_injector.sv
// PE-side NoC transmitter: frames a packet command plus buffered payload words
// into HEAD/BODY/TAIL flits for the local router's PE input port.
module noc_pe_injector
   import noc_pkg::*;
#(
   parameter logic [3:0]  NODE_ID    = 4'd0,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned MAX_LEN    = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_dest,
   input  logic [7:0]        cmd_len,
   input  logic              dat_valid,
   output logic              dat_ready,
   input  logic [DATA_W-1:0] dat_data,
   output logic              flit_valid,
   input  logic              flit_ready,
   output logic [DATA_W+1:0] flit_data,
   output logic              busy,
   output logic              pkt_sent,
   output logic              cmd_err
);
   typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY} state_e;

   state_e            state_q, state_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        rem_q, rem_d;
   logic [15:0]       seq_q, seq_d;
   logic              busy_q, busy_d;
   logic              flit_valid_q, flit_valid_d;
   logic [DATA_W+1:0] flit_data_q, flit_data_d;
   logic              cmd_err_q, cmd_err_d;

   logic [DATA_W-1:0] head_pl, fifo_data;
   logic              fifo_pop, fifo_empty, fifo_full;
   logic              cmd_fire, len_ok, out_free, tail_fire;
   logic [7:0]        avail_cnt;
   flit_type_e        word_type;

   noc_sync_fifo #(
      .WIDTH(DATA_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (dat_valid),
      .push_data(dat_data),
      .full     (fifo_full),
      .pop      (fifo_pop),
      .pop_data (fifo_data),
      .empty    (fifo_empty)
   );

   assign cmd_ready = rst_n && (state_q == ST_IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign len_ok    = (cmd_len != 8'd0) && (32'(cmd_len) <= MAX_LEN);
   assign out_free  = !flit_valid_q || flit_ready;
   assign tail_fire = flit_valid_q && flit_ready && (flit_data_q[DATA_W+1:DATA_W] == FLIT_TAIL);
   // In HEAD nothing has been popped yet, so the whole length is still owed.
   assign avail_cnt = (state_q == ST_HEAD) ? len_q : rem_q;
   assign word_type = (avail_cnt == 8'd1) ? FLIT_TAIL : FLIT_BODY;

   always_comb begin
      head_pl = '0;
      head_pl[HDR_DEST_LSB +: HDR_DEST_W] = cmd_dest;
      head_pl[HDR_SRC_LSB  +: HDR_SRC_W]  = NODE_ID;
      head_pl[HDR_LEN_LSB  +: HDR_LEN_W]  = cmd_len;
      head_pl[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq_q;
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      rem_d        = rem_q;
      seq_d        = seq_q;
      busy_d       = busy_q;
      flit_valid_d = flit_valid_q;
      flit_data_d  = flit_data_q;
      cmd_err_d    = 1'b0;
      fifo_pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               if (len_ok) begin
                  len_d        = cmd_len;
                  busy_d       = 1'b1;
                  flit_valid_d = 1'b1;
                  flit_data_d  = {FLIT_HEAD, head_pl};
                  state_d      = ST_HEAD;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         ST_HEAD, ST_BODY: begin
            if (tail_fire) begin
               seq_d        = seq_q + 16'd1;
               busy_d       = 1'b0;
               flit_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end else if (out_free) begin
               // Refill the output register in the handshake cycle to sustain 1 flit/cycle.
               state_d      = ST_BODY;
               rem_d        = avail_cnt;
               flit_valid_d = 1'b0;
               if ((avail_cnt != 8'd0) && !fifo_empty) begin
                  fifo_pop     = 1'b1;
                  flit_valid_d = 1'b1;
                  flit_data_d  = {word_type, fifo_data};
                  rem_d        = avail_cnt - 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         rem_q        <= '0;
         seq_q        <= '0;
         busy_q       <= 1'b0;
         flit_valid_q <= 1'b0;
         flit_data_q  <= '0;
         cmd_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         rem_q        <= rem_d;
         seq_q        <= seq_d;
         busy_q       <= busy_d;
         flit_valid_q <= flit_valid_d;
         flit_data_q  <= flit_data_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   assign dat_ready  = !fifo_full;
   assign flit_valid = flit_valid_q;
   assign flit_data  = flit_data_q;
   assign busy       = busy_q;
   assign pkt_sent   = tail_fire;
   assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_noc_pe_injector.sv
// Bench for noc_pe_injector (NODE_ID=5): random payloads and flit_ready patterns
// checked against a packet-level model of the expected flit stream.
module tb_noc_pe_injector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_dest = '0;
   logic [7:0]  cmd_len = '0;
   logic        dat_valid = 1'b0;
   logic        dat_ready;
   logic [31:0] dat_data = '0;
   logic        flit_valid;
   logic        flit_ready = 1'b0;
   logic [33:0] flit_data;
   logic        busy, pkt_sent, cmd_err;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned rdy_mode = 0;
   logic [15:0] exp_seq = '0;
   logic [33:0] exp_q[$];

   // monitor state (written only by the monitor process)
   logic [33:0] mon_q[$];
   int unsigned n_sent = 0, n_err = 0, n_bubble = 0, hold_viol = 0, sent_bad = 0;
   bit          hold_pend = 0;
   logic [33:0] hold_data = '0;

   noc_pe_injector #(
      .NODE_ID   (4'd5),
      .DATA_W    (32),
      .FIFO_DEPTH(8),
      .MAX_LEN   (255)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dest  (cmd_dest),
      .cmd_len   (cmd_len),
      .dat_valid (dat_valid),
      .dat_ready (dat_ready),
      .dat_data  (dat_data),
      .flit_valid(flit_valid),
      .flit_ready(flit_ready),
      .flit_data (flit_data),
      .busy      (busy),
      .pkt_sent  (pkt_sent),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       flit_ready = 1'b1;
         1:       flit_ready = !flit_ready;
         2:       flit_ready = 1'($urandom_range(1, 0));
         default: flit_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (flit_valid && flit_ready) mon_q.push_back(flit_data);
         if (pkt_sent) n_sent++;
         if (cmd_err) n_err++;
         if (busy && !flit_valid) n_bubble++;
         if (pkt_sent != (flit_valid && flit_ready && flit_data[33:32] == 2'b10)) sent_bad++;
         if (hold_pend && (!flit_valid || flit_data !== hold_data)) hold_viol++;
         hold_pend = flit_valid && !flit_ready;
         hold_data = flit_data;
      end else begin
         hold_pend = 0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic idle(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_word(input logic [31:0] w);
      dat_valid = 1'b1;
      dat_data  = w;
      for (int unsigned i = 0; i < 500; i++) begin
         @(negedge clk);
         if (dat_ready) begin @(posedge clk); #1; break; end
         @(posedge clk); #1;
      end
      dat_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [3:0] dest, input logic [7:0] len);
      cmd_valid = 1'b1;
      cmd_dest  = dest;
      cmd_len   = len;
      for (int unsigned i = 0; i < 500; i++) begin
         @(negedge clk);
         if (cmd_ready) begin @(posedge clk); #1; break; end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_flits(input int unsigned target, input int unsigned budget, output bit ok);
      ok = 0;
      for (int unsigned i = 0; i < budget; i++) begin
         if (mon_q.size() >= target) begin ok = 1; break; end
         @(posedge clk); #1;
      end
   endtask

   // order: 0 = words and command concurrently, 1 = words first, 2 = command first
   task automatic drive_pkt(input logic [3:0] dest, input logic [7:0] len, input int unsigned order,
                            input int unsigned gap_min, input int unsigned gap_max);
      logic [31:0] w[$];
      exp_q.delete();
      exp_q.push_back({2'b01, dest, 4'd5, len, exp_seq});
      for (int unsigned i = 0; i < len; i++) begin
         w.push_back($urandom);
         exp_q.push_back({(i == 32'(len) - 1) ? 2'b10 : 2'b00, w[i]});
      end
      if (order == 2) send_cmd(dest, len);
      if (order == 0) begin
         fork
            begin
               for (int unsigned i = 0; i < w.size(); i++) begin
                  push_word(w[i]);
                  idle($urandom_range(gap_max, gap_min));
               end
            end
            send_cmd(dest, len);
         join
      end else begin
         for (int unsigned i = 0; i < w.size(); i++) begin
            push_word(w[i]);
            idle($urandom_range(gap_max, gap_min));
         end
      end
      if (order == 1) send_cmd(dest, len);
   endtask

   task automatic test_reset();
      #12;
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready_low: got=%b want=0", cmd_ready); end
      total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL rst_flit_valid: got=%b want=0", flit_valid); end
      total++; if (flit_data !== 34'h0) begin bad++; $display("FAIL rst_flit_data: got=%h want=0", flit_data); end
      total++; if ({busy, pkt_sent, cmd_err} !== 3'b000) begin bad++; $display("FAIL rst_flags: got=%b want=000", {busy, pkt_sent, cmd_err}); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready_rel: got=%b want=1", cmd_ready); end
      total++; if (dat_ready !== 1'b1) begin bad++; $display("FAIL rst_dat_ready: got=%b want=1", dat_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [33:0] exp[4];
      int unsigned mb = mon_q.size(), s0 = n_sent, e0 = n_err;
      bit ok;
      logic [33:0] got;
      exp[0] = 34'h1_A503_0000; exp[1] = {2'b00, 32'hA}; exp[2] = {2'b00, 32'hB}; exp[3] = {2'b10, 32'hC};
      rdy_mode = 0;
      push_word(32'hA); push_word(32'hB); push_word(32'hC);
      send_cmd(4'hA, 8'd3);
      wait_flits(mb + 4, 50, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got=%0d flits want=4", mon_q.size() - mb); end
      for (int unsigned i = 0; i < 4; i++) begin
         got = (mb + i < mon_q.size()) ? mon_q[mb + i] : 'x;
         total++; if (got !== exp[i]) begin bad++; $display("FAIL basic_flit[%0d]: got=%h want=%h", i, got, exp[i]); end
      end
      idle(2);
      exp_seq = exp_seq + 16'd1;
      total++; if (n_sent - s0 != 1) begin bad++; $display("FAIL basic_pkt_sent: got=%0d pulses want=1", n_sent - s0); end
      total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_idle: got busy=%b cmd_ready=%b want 0/1", busy, cmd_ready); end
      total++; if (n_err != e0) begin bad++; $display("FAIL basic_no_err: got=%0d want=%0d", n_err, e0); end
   endtask

   task automatic test_error();
      int unsigned mb = mon_q.size(), e0 = n_err;
      send_cmd(4'h7, 8'd0);
      idle(4);
      total++; if (n_err - e0 != 1) begin bad++; $display("FAIL err_pulse: got=%0d cycles want=1", n_err - e0); end
      total++; if (mon_q.size() != mb) begin bad++; $display("FAIL err_no_flits: got=%0d want=0", mon_q.size() - mb); end
      total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL err_idle: got busy=%b cmd_ready=%b want 0/1", busy, cmd_ready); end
   endtask

   task automatic test_backpressure();
      int unsigned mb = mon_q.size(), h0 = hold_viol, sb0 = sent_bad;
      bit ok;
      logic [33:0] got;
      rdy_mode = 1;
      drive_pkt(4'hA, 8'd3, 1, 0, 0);
      wait_flits(mb + exp_q.size(), 100, ok);
      idle(3);
      total++; if (!ok || mon_q.size() - mb != exp_q.size()) begin bad++; $display("FAIL bp_count: got=%0d want=%0d", mon_q.size() - mb, exp_q.size()); end
      for (int unsigned i = 0; i < exp_q.size(); i++) begin
         got = (mb + i < mon_q.size()) ? mon_q[mb + i] : 'x;
         total++; if (got !== exp_q[i]) begin bad++; $display("FAIL bp_flit[%0d]: got=%h want=%h", i, got, exp_q[i]); end
      end
      total++; if (hold_viol != h0) begin bad++; $display("FAIL bp_hold: got=%0d violations want=0", hold_viol - h0); end
      total++; if (sent_bad != sb0) begin bad++; $display("FAIL bp_pkt_sent: got=%0d mismatches want=0", sent_bad - sb0); end
      exp_seq = exp_seq + 16'd1;
      rdy_mode = 0;
   endtask

   task automatic test_starvation();
      int unsigned mb = mon_q.size(), b0 = n_bubble;
      bit ok;
      logic [33:0] got;
      rdy_mode = 0;
      drive_pkt(4'hC, 8'd4, 2, 2, 2);
      wait_flits(mb + exp_q.size(), 100, ok);
      idle(2);
      total++; if (!ok || mon_q.size() - mb != exp_q.size()) begin bad++; $display("FAIL starve_count: got=%0d want=%0d", mon_q.size() - mb, exp_q.size()); end
      for (int unsigned i = 0; i < exp_q.size(); i++) begin
         got = (mb + i < mon_q.size()) ? mon_q[mb + i] : 'x;
         total++; if (got !== exp_q[i]) begin bad++; $display("FAIL starve_flit[%0d]: got=%h want=%h", i, got, exp_q[i]); end
      end
      total++; if (n_bubble - b0 < 4) begin bad++; $display("FAIL starve_bubbles: got=%0d want>=4", n_bubble - b0); end
      exp_seq = exp_seq + 16'd1;
   endtask

   task automatic test_full();
      logic [31:0] w[9];
      int unsigned mb;
      bit ok;
      logic [33:0] got, want;
      logic [31:0] fresh = $urandom;
      for (int unsigned i = 0; i < 9; i++) w[i] = $urandom;
      rdy_mode = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         push_word(w[i]);
         if (i == 6) begin
            @(negedge clk);
            total++; if (dat_ready !== 1'b1) begin bad++; $display("FAIL full_ready_at7: got=%b want=1", dat_ready); end
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      total++; if (dat_ready !== 1'b0) begin bad++; $display("FAIL full_ready_at8: got=%b want=0", dat_ready); end
      @(posedge clk); #1;
      dat_valid = 1'b1; dat_data = w[8];
      @(posedge clk); #1;
      dat_valid = 1'b0;
      mb = mon_q.size();
      send_cmd(4'h3, 8'd8);
      wait_flits(mb + 9, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_timeout: got=%0d want=9", mon_q.size() - mb); end
      for (int unsigned i = 0; i < 9; i++) begin
         want = (i == 0) ? {2'b01, 4'h3, 4'd5, 8'd8, exp_seq} : {(i == 8) ? 2'b10 : 2'b00, w[i-1]};
         got = (mb + i < mon_q.size()) ? mon_q[mb + i] : 'x;
         total++; if (got !== want) begin bad++; $display("FAIL full_flit[%0d]: got=%h want=%h", i, got, want); end
      end
      exp_seq = exp_seq + 16'd1;
      idle(2);
      mb = mon_q.size();
      send_cmd(4'h3, 8'd1);
      idle(6);
      total++; if (mon_q.size() - mb != 1 || flit_valid !== 1'b0) begin bad++; $display("FAIL full_drop9: got flits=%0d valid=%b want 1/0", mon_q.size() - mb, flit_valid); end
      push_word(fresh);
      wait_flits(mb + 2, 20, ok);
      got = (mb + 1 < mon_q.size()) ? mon_q[mb + 1] : 'x;
      total++; if (got !== {2'b10, fresh}) begin bad++; $display("FAIL full_next_tail: got=%h want=%h", got, {2'b10, fresh}); end
      exp_seq = exp_seq + 16'd1;
      idle(2);
   endtask

   task automatic test_random();
      bit ok;
      logic [33:0] got;
      rdy_mode = 2;
      for (int unsigned p = 0; p < 8; p++) begin
         int unsigned mb = mon_q.size(), s0 = n_sent, sb0 = sent_bad, h0 = hold_viol;
         logic [3:0] dest = (p == 3) ? 4'd5 : 4'($urandom);
         logic [7:0] len = 8'($urandom_range(20, 1));
         drive_pkt(dest, len, 0, 0, 2);
         wait_flits(mb + exp_q.size(), 1000, ok);
         idle(3);
         total++; if (!ok || mon_q.size() - mb != exp_q.size()) begin bad++; $display("FAIL rand%0d_count: got=%0d want=%0d", p, mon_q.size() - mb, exp_q.size()); end
         for (int unsigned i = 0; i < exp_q.size(); i++) begin
            got = (mb + i < mon_q.size()) ? mon_q[mb + i] : 'x;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL rand%0d_flit[%0d]: got=%h want=%h", p, i, got, exp_q[i]); end
         end
         total++; if (n_sent - s0 != 1 || sent_bad != sb0 || hold_viol != h0) begin
            bad++; $display("FAIL rand%0d_proto: got sent=%0d sent_bad=%0d hold=%0d want 1/0/0", p, n_sent - s0, sent_bad - sb0, hold_viol - h0);
         end
         exp_seq = exp_seq + 16'd1;
      end
      rdy_mode = 0;
      idle(2);
   endtask

   task automatic test_seq_wrap();
      bit ok;
      logic [33:0] got;
      force dut.seq_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.seq_q;
      exp_seq = 16'hFFFF;
      rdy_mode = 0;
      for (int unsigned p = 0; p < 2; p++) begin
         int unsigned mb = mon_q.size();
         drive_pkt(4'h1, 8'd1, 1, 0, 0);
         wait_flits(mb + 2, 50, ok);
         got = (mb < mon_q.size()) ? mon_q[mb] : 'x;
         total++; if (got !== exp_q[0]) begin bad++; $display("FAIL wrap%0d_head: got=%h want=%h", p, got, exp_q[0]); end
         exp_seq = exp_seq + 16'd1;
         idle(2);
      end
   endtask

   task automatic test_reset_mid();
      int unsigned mb;
      bit ok;
      logic [33:0] got;
      logic [31:0] fresh = $urandom;
      rdy_mode = 0;
      mb = mon_q.size();
      drive_pkt(4'h9, 8'd5, 1, 0, 0);
      for (int unsigned i = 0; i < 100 && mon_q.size() < mb + 4; i++) begin @(negedge clk); #1; end
      rdy_mode = 3;
      @(posedge clk); #1;
      idle(2);
      total++; if (flit_valid !== 1'b1 || flit_data !== exp_q[4]) begin bad++; $display("FAIL mid_held: got valid=%b data=%h want 1/%h", flit_valid, flit_data, exp_q[4]); end
      #3; rst_n = 1'b0; #1;
      total++; if (flit_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_async: got valid=%b busy=%b want 0/0", flit_valid, busy); end
      total++; if (cmd_ready !== 1'b0 || pkt_sent !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got cmd_ready=%b pkt_sent=%b want 0/0", cmd_ready, pkt_sent); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rdy_mode = 0;
      exp_seq = '0;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1 || dat_ready !== 1'b1) begin bad++; $display("FAIL mid_release: got cmd_ready=%b dat_ready=%b want 1/1", cmd_ready, dat_ready); end
      @(posedge clk); #1;
      mb = mon_q.size();
      send_cmd(4'h9, 8'd1);
      idle(6);
      got = (mb < mon_q.size()) ? mon_q[mb] : 'x;
      total++; if (got !== {2'b01, 4'h9, 4'd5, 8'd1, exp_seq}) begin bad++; $display("FAIL mid_head: got=%h want=%h", got, {2'b01, 4'h9, 4'd5, 8'd1, exp_seq}); end
      total++; if (mon_q.size() - mb != 1 || flit_valid !== 1'b0) begin bad++; $display("FAIL mid_fifo_empty: got flits=%0d valid=%b want 1/0", mon_q.size() - mb, flit_valid); end
      push_word(fresh);
      wait_flits(mb + 2, 20, ok);
      got = (mb + 1 < mon_q.size()) ? mon_q[mb + 1] : 'x;
      total++; if (got !== {2'b10, fresh}) begin bad++; $display("FAIL mid_tail: got=%h want=%h", got, {2'b10, fresh}); end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_backpressure();
      test_starvation();
      test_full();
      test_random();
      test_seq_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
